// File: rtl/fetch_sequencer_if.sv
// Fetch-sequencer handshake bundle: control from hazard/branch logic in, fetch address and status out.
interface fetch_sequencer_if #(
    parameter int unsigned PC_W = 32
);
    logic            start;
    logic            stall;
    logic            br_taken;
    logic [PC_W-1:0] br_target;
    logic            halt_req;
    logic [PC_W-1:0] pc;
    logic            fetch_valid;
    logic            flush;
    logic            done;
    logic            err;
    logic [7:0]      instr_count;

    modport master (
        output start, stall, br_taken, br_target, halt_req,
        input  pc, fetch_valid, flush, done, err, instr_count
    );

    modport slave (
        input  start, stall, br_taken, br_target, halt_req,
        output pc, fetch_valid, flush, done, err, instr_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter owner for the IF stage: start, sequential fetch, stalls, redirects with
// flush bubbles, end-of-program detection and halt.
module fetch_sequencer #(
    parameter int unsigned PC_W         = 32,
    parameter int unsigned IMEM_BYTES   = 24,
    parameter int unsigned RESET_PC     = 0,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic               clk,
    input logic               rst,
    fetch_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StRun, StFlush, StHalt} state_e;

    localparam logic [PC_W-1:0] ResetPc    = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] LastPc     = PC_W'(IMEM_BYTES - 4);
    localparam logic [PC_W-1:0] ImemEnd    = PC_W'(IMEM_BYTES);
    localparam logic [2:0]      BubbleInit = 3'(FLUSH_CYCLES - 1);

    state_e          state_q;
    logic [PC_W-1:0] pc_q;
    logic            flush_q;
    logic            done_q;
    logic            err_q;
    logic [7:0]      count_q;
    logic [2:0]      bubble_q;
    logic            fetch_valid;
    logic [PC_W-1:0] target;

    assign fetch_valid = (state_q == StRun) && !bus.stall;
    assign target      = bus.br_target & ~PC_W'(3);

    assign bus.pc          = pc_q;
    assign bus.fetch_valid = fetch_valid;
    assign bus.flush       = flush_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.instr_count = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            pc_q     <= ResetPc;
            flush_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= 8'd0;
            bubble_q <= 3'd0;
        end else begin
            if (fetch_valid && count_q != 8'hFF) begin
                count_q <= count_q + 8'd1;
            end
            unique case (state_q)
                StIdle: begin
                    if (bus.start) state_q <= StRun;
                end
                StRun: begin
                    if (bus.halt_req) begin
                        state_q <= StHalt;
                        done_q  <= 1'b1;
                    end else if (bus.br_taken) begin
                        if (target < ImemEnd) begin
                            pc_q     <= target;
                            flush_q  <= 1'b1;
                            bubble_q <= BubbleInit;
                            state_q  <= StFlush;
                        end else begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= StHalt;
                        end
                    end else if (!bus.stall) begin
                        // The last word is fetched this cycle; pc never wraps past it.
                        if (pc_q == LastPc) begin
                            done_q  <= 1'b1;
                            state_q <= StHalt;
                        end else begin
                            pc_q <= pc_q + PC_W'(4);
                        end
                    end
                end
                StFlush: begin
                    if (bus.halt_req) begin
                        flush_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StHalt;
                    end else if (bubble_q == 3'd0) begin
                        flush_q <= 1'b0;
                        state_q <= StRun;
                    end else begin
                        bubble_q <= bubble_q - 3'd1;
                    end
                end
                StHalt: begin
                    if (bus.start) begin
                        pc_q    <= ResetPc;
                        err_q   <= 1'b0;
                        count_q <= 8'd0;
                        done_q  <= 1'b0;
                        state_q <= StRun;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controller that owns the program counter for the instruction-fetch stage and sequences it through start, sequential fetch, load-use stalls, taken-branch redirects with pipeline flush, end-of-program detection and halt. The block sits between the hazard/branch logic in ID/EX and the instruction memory read port. It drives the fetch address plus a valid/flush pair into the IF/ID pipeline register.

## Interface
- PC_W, 32, program counter width
- IMEM_BYTES, 24, instruction memory size in bytes; multiple of 4
- RESET_PC, 0, start address; word aligned
- FLUSH_CYCLES, 2, bubble cycles inserted after a redirect; 1..7

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin fetching; sampled in IDLE and HALT
- stall  in  1  hold current PC (load-use hazard)
- br_taken  in  1  redirect request from EX
- br_target  in  PC_W  redirect address; bits [1:0] ignored, forced 0
- halt_req  in  1  stop fetching
- pc  out  PC_W  fetch address to instruction memory; registered
- fetch_valid  out  1  instruction at pc is valid into IF/ID; combinational
- flush  out  1  kill younger instructions in IF/ID and ID/EX; registered
- done  out  1  sequencer in HALT; registered
- err  out  1  halted because of an out-of-range branch target; sticky until start
- instr_count  out  8  count of valid fetches, saturating at 255

## Operation
- States: IDLE, RUN, FLUSH, HALT. A 3-bit bubble counter is used only in FLUSH.
- IDLE:
  - pc = RESET_PC, fetch_valid = 0.
  - start moves to RUN.
- RUN:
  - fetch_valid = !stall.
  - Priority: halt_req > br_taken > stall > sequential.
  - halt_req: go to HALT, pc holds.
  - br_taken with target < IMEM_BYTES: pc <= {target[PC_W-1:2],2'b00}, flush <= 1, counter <= FLUSH_CYCLES-1, go to FLUSH.
  - br_taken with target >= IMEM_BYTES: go to HALT, err <= 1, pc holds.
  - stall: pc holds.
  - Sequential case with pc == IMEM_BYTES-4: the last word is fetched this cycle, then go to HALT and pc holds. pc never wraps.
  - Otherwise: pc <= pc + 4, with width PC_W and no carry out.
- FLUSH:
  - fetch_valid = 0, flush = 1, pc holds the target.
  - stall and br_taken are ignored.
  - halt_req goes to HALT with flush <= 0.
  - When the counter is 0: flush <= 0, go to RUN. Otherwise decrement the counter.
- HALT:
  - done = 1, fetch_valid = 0, pc holds.
  - start: pc <= RESET_PC, err <= 0, instr_count <= 0, done <= 0, go to RUN.
- instr_count increments in any cycle with fetch_valid = 1. It holds at 255.
- start in RUN or FLUSH is ignored.

## Timing
- Reset values: state IDLE, pc = RESET_PC, fetch_valid 0, flush 0, done 0, err 0, instr_count 0, counter 0. Reset takes effect immediately and asynchronously, including mid-FLUSH.
- Start latency: start high at edge N gives RUN after N, with fetch_valid high in cycle N+1 at pc = RESET_PC.
- Sequential fetch is 1 word per cycle. pc advances on each edge where RUN && !stall && !br_taken && !halt_req.
- Redirect: br_taken sampled at edge N gives pc = target and flush = 1 after N. fetch_valid is 0 for exactly FLUSH_CYCLES cycles. The target is first presented valid in cycle N+FLUSH_CYCLES+1.
- Simultaneous events:
  - br_taken and stall together: the redirect wins and the stall is dropped.
  - halt_req and br_taken together: HALT, no flush, err unchanged.
- done rises the cycle after the transition edge into HALT.

## Test plan
- Reset then start with IMEM_BYTES = 24 and no stalls -> pc steps 0, 4, 8, 12, 16, 20 with fetch_valid high for 6 cycles. Then done = 1, pc = 20, instr_count = 6.
- Stall held 3 cycles at pc = 8 -> pc stays 8, fetch_valid low for 3 cycles, instr_count unchanged. pc = 12 follows on the first unstalled edge.
- br_taken at pc = 12 with target 0x06 -> pc = 4, flush high for 2 cycles with fetch_valid low. RUN resumes fetching at 4.
- br_taken with target 0x40 -> HALT, err = 1, done = 1, pc holds. A following start -> err = 0, pc = 0, instr_count = 0.
- halt_req and br_taken in the same cycle -> HALT, flush stays 0, pc unchanged. rst asserted mid-FLUSH -> all outputs return to reset values immediately.
- 300-word looping program via repeated branches to 0 -> instr_count saturates at 255 and holds.
